// File: rtl/uart_tx_core.sv
// uart_tx_core
// Transmit half of the UART. Bytes written on wr_uart/w_data go into a
// small TX FIFO. An FSM pops them and sends each one as an 8N1 frame on tx:
// a start bit, DBIT data bits LSB-first, then the stop bit(s). Timing comes
// from a free-running 16x-oversample baud tick.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   dvsr      baud divisor; one oversample tick every dvsr+1 clk
//   wr_uart   push strobe, one byte per cycle while high
//   w_data    byte to push (DBIT LSBs used)
//   tx_full   FIFO holds 2**FIFO_W entries
//   tx_empty  FIFO holds no entries
//   tx_busy   a frame is in progress (FSM not idle)
//   tx        serial line, idle high, registered
`timescale 1ns/1ps

module uart_tx_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 4,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              wr_uart,
    input  logic [7:0]        w_data,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              tx_busy,
    output logic              tx
);

    localparam int DEPTH = 2**FIFO_W;
    // The tick counter must reach SB_TICK-1 in STOP, so it grows for 2-stop-bit builds.
    localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [DVSR_W-1:0] b_cnt;
    logic              tick;
    logic [S_W-1:0]    s_cnt;
    logic [N_W-1:0]    n_cnt;
    logic [DBIT-1:0]   b_reg;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W:0]   count;
    logic              push;
    logic              pop;

    // The baud counter free-runs. Using >= rather than == means that lowering
    // dvsr below the current count gives one early tick and never a wrap
    // through the full counter range.
    assign tick = (b_cnt >= dvsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt <= '0;
        end else if (tick) begin
            b_cnt <= '0;
        end else begin
            b_cnt <= b_cnt + DVSR_W'(1);
        end
    end

    // A push while full is dropped even if a pop happens in the same cycle.
    // This keeps the full flag a pure decode of the registered count.
    assign push     = wr_uart && !tx_full;
    assign pop      = (state == IDLE) && !tx_empty;
    assign tx_full  = (count == FULL_CNT);
    assign tx_empty = (count == '0);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data[DBIT-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_W+1)'(1);
                2'b01:   count <= count - (FIFO_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            b_reg <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        b_reg <= mem[rd_ptr];
                        s_cnt <= '0;
                        state <= START;
                        tx    <= 1'b0;
                    end else begin
                        tx    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt == S_W'(15)) begin
                            s_cnt <= '0;
                            n_cnt <= '0;
                            state <= DATA;
                            tx    <= b_reg[0];
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == S_W'(15)) begin
                            s_cnt <= '0;
                            b_reg <= b_reg >> 1;
                            if (n_cnt == N_W'(DBIT-1)) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                n_cnt <= n_cnt + N_W'(1);
                                tx    <= b_reg[1];
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_cnt == S_W'(SB_TICK-1)) begin
                            s_cnt <= '0;
                            state <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
